// File: rtl/bnn_neuron_feeder.sv
// bnn_neuron_feeder: buffers one binary activation vector and replays it chunk by chunk to a neuron, paired with that neuron's weights and threshold
module bnn_neuron_feeder #(
  parameter int PW = 8,
  parameter int IN_BITS = 64,
  parameter int NUM_NEURONS = 4,
  parameter int THRESH_W = 16,
  localparam int CHUNKS = IN_BITS / PW,
  localparam int CW = CHUNKS > 1 ? $clog2(CHUNKS) : 1,
  localparam int NW = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1,
  localparam int WAW = NUM_NEURONS * CHUNKS > 1 ? $clog2(NUM_NEURONS * CHUNKS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PW-1:0]       in_data,
  output logic                w_rd_en,
  output logic [WAW-1:0]      w_rd_addr,
  input  logic [PW-1:0]       w_rd_data,
  output logic                t_rd_en,
  output logic [NW-1:0]       t_rd_addr,
  input  logic [THRESH_W-1:0] t_rd_data,
  output logic [PW-1:0]       x,
  output logic [PW-1:0]       w,
  output logic [THRESH_W-1:0] thresh,
  output logic                valid_out,
  output logic                last_out,
  output logic [NW-1:0]       neuron_id,
  output logic                done
);
  typedef enum logic [1:0] {LOAD, STREAM, FLUSH} state_t;
  localparam logic [CW-1:0] C_LAST = CW'(CHUNKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NUM_NEURONS - 1);
  state_t state;
  logic [PW-1:0] vec [CHUNKS];
  logic [CW-1:0] load_ptr, chunk;
  logic [NW-1:0] neuron;
  logic [WAW-1:0] addr;
  logic issue, chunk_end, layer_end;
  assign in_ready = state == LOAD && !rst;
  assign issue = state == STREAM && !rst;
  assign chunk_end = chunk == C_LAST;
  assign layer_end = chunk_end && neuron == N_LAST;
  assign w_rd_en = issue;
  assign t_rd_en = issue;
  assign w_rd_addr = addr;
  assign t_rd_addr = neuron;
  // memory data lands in the same cycle as the pipe register, so it passes straight through
  assign w = valid_out ? w_rd_data : '0;
  assign thresh = valid_out ? t_rd_data : '0;
  always_ff @(posedge clk)
    if (in_valid && in_ready) vec[load_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      load_ptr <= '0;
      chunk <= '0;
      neuron <= '0;
      addr <= '0;
      x <= '0;
      neuron_id <= '0;
      valid_out <= 1'b0;
      last_out <= 1'b0;
      done <= 1'b0;
    end else begin
      valid_out <= issue;
      last_out <= issue && chunk_end;
      done <= issue && layer_end;
      if (issue) begin
        x <= vec[chunk];
        neuron_id <= neuron;
      end
      case (state)
        LOAD: if (in_valid) begin
          load_ptr <= load_ptr == C_LAST ? '0 : load_ptr + 1'b1;
          if (load_ptr == C_LAST) state <= STREAM;
        end
        STREAM: begin
          chunk <= chunk_end ? '0 : chunk + 1'b1;
          addr <= layer_end ? '0 : addr + 1'b1;
          if (chunk_end) neuron <= neuron == N_LAST ? '0 : neuron + 1'b1;
          if (layer_end) state <= FLUSH;
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_bnn_neuron_feeder.sv
// tb_bnn_neuron_feeder: directed checks of a 3-neuron/2-chunk feeder and a 1-neuron/1-chunk edge feeder
module tb_bnn_neuron_feeder;
  logic clk = 1'b0, rst = 1'b1;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  logic a_in_valid = 1'b0, a_in_ready, a_w_rd_en, a_t_rd_en, a_valid, a_last, a_done;
  logic [7:0] a_in_data = '0, a_w_rd_data, a_x, a_w;
  logic [2:0] a_w_rd_addr;
  logic [1:0] a_t_rd_addr, a_id;
  logic [15:0] a_t_rd_data, a_thresh;

  logic b_in_valid = 1'b0, b_in_ready, b_w_rd_en, b_t_rd_en, b_valid, b_last, b_done;
  logic [7:0] b_in_data = '0, b_w_rd_data, b_x, b_w;
  logic [0:0] b_w_rd_addr, b_t_rd_addr, b_id;
  logic [15:0] b_t_rd_data, b_thresh;

  bnn_neuron_feeder #(.PW(8), .IN_BITS(16), .NUM_NEURONS(3), .THRESH_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .w_rd_en(a_w_rd_en), .w_rd_addr(a_w_rd_addr), .w_rd_data(a_w_rd_data),
    .t_rd_en(a_t_rd_en), .t_rd_addr(a_t_rd_addr), .t_rd_data(a_t_rd_data),
    .x(a_x), .w(a_w), .thresh(a_thresh), .valid_out(a_valid), .last_out(a_last),
    .neuron_id(a_id), .done(a_done));

  bnn_neuron_feeder #(.PW(8), .IN_BITS(8), .NUM_NEURONS(1), .THRESH_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .w_rd_en(b_w_rd_en), .w_rd_addr(b_w_rd_addr), .w_rd_data(b_w_rd_data),
    .t_rd_en(b_t_rd_en), .t_rd_addr(b_t_rd_addr), .t_rd_data(b_t_rd_data),
    .x(b_x), .w(b_w), .thresh(b_thresh), .valid_out(b_valid), .last_out(b_last),
    .neuron_id(b_id), .done(b_done));

  // 1-cycle-latency memories: weight[i] = 0x10+i, thresh[n] = 100+n
  always @(posedge clk) begin
    if (a_w_rd_en) a_w_rd_data <= 8'h10 + 8'(a_w_rd_addr);
    if (a_t_rd_en) a_t_rd_data <= 16'd100 + 16'(a_t_rd_addr);
    if (b_w_rd_en) b_w_rd_data <= 8'h10 + 8'(b_w_rd_addr);
    if (b_t_rd_en) b_t_rd_data <= 16'd100 + 16'(b_t_rd_addr);
  end

  task automatic drive_a(input logic v, input logic [7:0] d);
    @(negedge clk);
    a_in_valid = v;
    a_in_data = d;
  endtask

  // call right after the final load beat has been driven
  task automatic run_stream_a(input string name, input logic [7:0] x0, input logic [7:0] x1, input logic hold);
    logic [36:0] got, exp;
    @(negedge clk);
    tests++;
    if ({a_valid, a_in_ready} !== 2'b00) begin
      fails++;
      $display("FAIL %s latency: valid_out,in_ready=%b, want 00", name, {a_valid, a_in_ready});
    end
    a_in_valid = hold;
    a_in_data = 8'hFF;
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      got = {a_valid, a_x, a_w, a_thresh, a_last, a_id, a_done};
      exp = {1'b1, (b % 2) ? x1 : x0, 8'(8'h10 + b), 16'(100 + b / 2), 1'(b % 2), 2'(b / 2), b == 5};
      tests++;
      if (got !== exp || a_in_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s beat%0d: got %h ready=%b, want %h ready=0", name, b, got, a_in_ready, exp);
      end
    end
    @(negedge clk);
    tests++;
    if ({a_valid, a_done, a_in_ready} !== 3'b001) begin
      fails++;
      $display("FAIL %s end: valid,done,ready=%b, want 001", name, {a_valid, a_done, a_in_ready});
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({a_in_ready, b_in_ready, a_valid, a_last, a_done, a_w_rd_en, a_t_rd_en, a_x, a_w, a_thresh, a_id} !== '0) begin
      fails++;
      $display("FAIL reset_a: ready=%b valid=%b x=%h w=%h th=%h id=%h", a_in_ready, a_valid, a_x, a_w, a_thresh, a_id);
    end
    tests++;
    if ({b_valid, b_last, b_done, b_w_rd_en, b_t_rd_en, b_x, b_w, b_thresh, b_id} !== '0) begin
      fails++;
      $display("FAIL reset_b: valid=%b x=%h w=%h th=%h", b_valid, b_x, b_w, b_thresh);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({a_in_ready, b_in_ready} !== 2'b11) begin
      fails++;
      $display("FAIL reset_ready: got %b, want 11", {a_in_ready, b_in_ready});
    end
  endtask

  task automatic test_basic;
    drive_a(1'b1, 8'hA5);
    drive_a(1'b1, 8'h3C);
    run_stream_a("basic", 8'hA5, 8'h3C, 1'b0);
  endtask

  task automatic test_bubbles;
    drive_a(1'b1, 8'hA5);
    drive_a(1'b0, 8'h77);
    drive_a(1'b0, 8'h66);
    tests++;
    if (a_in_ready !== 1'b1 || a_valid !== 1'b0) begin
      fails++;
      $display("FAIL bubbles_gap: ready=%b valid=%b, want 1 0", a_in_ready, a_valid);
    end
    drive_a(1'b1, 8'h3C);
    run_stream_a("bubbles", 8'hA5, 8'h3C, 1'b0);
  endtask

  task automatic test_back_to_back;
    drive_a(1'b1, 8'hA5);
    drive_a(1'b1, 8'h3C);
    run_stream_a("ignore_ff", 8'hA5, 8'h3C, 1'b1);
    drive_a(1'b1, 8'h5C);
    drive_a(1'b1, 8'hC3);
    run_stream_a("reload", 8'h5C, 8'hC3, 1'b0);
  endtask

  task automatic test_reset_mid;
    drive_a(1'b1, 8'hA5);
    drive_a(1'b1, 8'h3C);
    drive_a(1'b0, 8'h00);
    repeat (3) @(negedge clk);
    tests++;
    if ({a_valid, a_x, a_id} !== {1'b1, 8'hA5, 2'd1}) begin
      fails++;
      $display("FAIL mid_beat3: valid=%b x=%h id=%0d, want 1 a5 1", a_valid, a_x, a_id);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({a_valid, a_last, a_done, a_in_ready, a_w_rd_en, a_x, a_w, a_id} !== '0) begin
      fails++;
      $display("FAIL mid_reset: valid=%b ready=%b x=%h w=%h id=%0d", a_valid, a_in_ready, a_x, a_w, a_id);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({a_in_ready, a_valid} !== 2'b10) begin
      fails++;
      $display("FAIL mid_after: ready,valid=%b, want 10", {a_in_ready, a_valid});
    end
    drive_a(1'b1, 8'h01);
    drive_a(1'b1, 8'h02);
    run_stream_a("after_reset", 8'h01, 8'h02, 1'b0);
  endtask

  task automatic test_edge_single;
    @(negedge clk);
    b_in_valid = 1'b1;
    b_in_data = 8'h5A;
    @(negedge clk);
    b_in_valid = 1'b0;
    tests++;
    if ({b_valid, b_in_ready} !== 2'b00) begin
      fails++;
      $display("FAIL edge_latency: valid,ready=%b, want 00", {b_valid, b_in_ready});
    end
    @(negedge clk);
    tests++;
    if ({b_valid, b_x, b_w, b_thresh, b_last, b_id, b_done} !== {1'b1, 8'h5A, 8'h10, 16'd100, 1'b1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL edge_beat: valid=%b x=%h w=%h th=%0d last=%b id=%0d done=%b, want 1 5a 10 100 1 0 1",
               b_valid, b_x, b_w, b_thresh, b_last, b_id, b_done);
    end
    @(negedge clk);
    tests++;
    if ({b_valid, b_done, b_in_ready} !== 3'b001) begin
      fails++;
      $display("FAIL edge_end: valid,done,ready=%b, want 001", {b_valid, b_done, b_in_ready});
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_bubbles;
    test_back_to_back;
    test_reset_mid;
    test_edge_single;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
